// File: rtl/hello_mem_test_pkg.sv
// Shared types and constants for the hello system on-chip RAM test master.
package hello_mem_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_e;

  localparam logic [1:0] MODE_NOP  = 2'b00;
  localparam logic [1:0] MODE_WR   = 2'b01;
  localparam logic [1:0] MODE_RD   = 2'b10;
  localparam logic [1:0] MODE_WRRD = 2'b11;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/hello_mem_test_rdpipe.sv
// Fixed-latency read tracker: carries expected words alongside their valid bits
// and flags a mismatch when an entry lines up with the returned read data.
module hello_mem_test_rdpipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 1
`ifdef HELLO_MEM_TEST_ERR_CAPTURE_EN
  ,
  parameter int ADDR_W = 15
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_exp,
`ifdef HELLO_MEM_TEST_ERR_CAPTURE_EN
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] cmp_addr,
  output logic [DATA_W-1:0] cmp_exp,
`endif
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              cmp_err
);

  logic [STAGES-1:0] vld_p;
  logic [DATA_W-1:0] exp_p [STAGES];
`ifdef HELLO_MEM_TEST_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] addr_p [STAGES];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= push;
      for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    exp_p[0] <= push_exp;
    for (int i = 1; i < STAGES; i++) exp_p[i] <= exp_p[i-1];
`ifdef HELLO_MEM_TEST_ERR_CAPTURE_EN
    addr_p[0] <= push_addr;
    for (int i = 1; i < STAGES; i++) addr_p[i] <= addr_p[i-1];
`endif
  end

  // Last stage: entry is aligned with the slave's returned data this cycle
  assign busy    = |vld_p;
  assign cmp_err = vld_p[STAGES-1] && (exp_p[STAGES-1] != rd_data);
`ifdef HELLO_MEM_TEST_ERR_CAPTURE_EN
  assign cmp_addr = addr_p[STAGES-1];
  assign cmp_exp  = exp_p[STAGES-1];
`endif

endmodule

// File: rtl/hello_mem_test_master.sv
// Avalon-MM initiator: writes seed+i over a wrapping word range, reads it back, counts mismatches.
// Optional first-mismatch capture ports are enabled by defining HELLO_MEM_TEST_ERR_CAPTURE_EN.
module hello_mem_test_master
  import hello_mem_test_pkg::*;
#(
  parameter int ADDR_W       = 15,
  parameter int DEPTH        = 25600,
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
`ifdef HELLO_MEM_TEST_ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [31:0]       first_err_exp,
  output logic [31:0]       first_err_got
`endif
);

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (int'(a) >= DEPTH - 1) ? '0 : a + ADDR_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] norm_addr(input logic [ADDR_W-1:0] a);
    return (int'(a) >= DEPTH) ? a - ADDR_W'(DEPTH) : a;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_e            state;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  left_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       seed_q;
  logic [CNT_W-1:0]  num_q;
  logic              accept;
  logic              last;
  logic              pipe_busy;
  logic              cmp_err;
`ifdef HELLO_MEM_TEST_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] cmp_addr;
  logic [31:0]       cmp_exp;
`endif

  assign accept         = avm_chipselect && (avm_read || avm_write) && !avm_waitrequest;
  assign last           = (left_q == CNT_W'(1));
  assign avm_byteenable = avm_chipselect ? BE_ALL : 4'h0;

  hello_mem_test_rdpipe #(
    .DATA_W (32),
    .STAGES (READ_LATENCY)
`ifdef HELLO_MEM_TEST_ERR_CAPTURE_EN
    ,
    .ADDR_W (ADDR_W)
`endif
  ) u_rdpipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (accept && avm_read),
    .push_exp (avm_writedata),
`ifdef HELLO_MEM_TEST_ERR_CAPTURE_EN
    .push_addr(avm_address),
    .cmp_addr (cmp_addr),
    .cmp_exp  (cmp_exp),
`endif
    .rd_data  (avm_readdata),
    .busy     (pipe_busy),
    .cmp_err  (cmp_err)
  );

  // Operands are only taken while idle, so a start during a run cannot disturb them
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      base_q <= norm_addr(base_addr);
      seed_q <= seed;
      num_q  <= num_words;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b1;
      err_count      <= '0;
      mode_q         <= MODE_NOP;
      left_q         <= '0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
`ifdef HELLO_MEM_TEST_ERR_CAPTURE_EN
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (cmp_err) err_count <= sat_inc(err_count);
`ifdef HELLO_MEM_TEST_ERR_CAPTURE_EN
      if (cmp_err && err_count == '0) begin
        first_err_addr <= cmp_addr;
        first_err_exp  <= cmp_exp;
        first_err_got  <= avm_readdata;
      end
`endif
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            pass      <= 1'b1;
            err_count <= '0;
`ifdef HELLO_MEM_TEST_ERR_CAPTURE_EN
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
`endif
            if (mode == MODE_NOP || num_words == '0) begin
              state <= DRAIN;
            end else begin
              mode_q         <= mode;
              left_q         <= num_words;
              avm_chipselect <= 1'b1;
              avm_address    <= norm_addr(base_addr);
              avm_writedata  <= seed;
              if (mode == MODE_RD) begin
                avm_read <= 1'b1;
                state    <= READ;
              end else begin
                avm_write <= 1'b1;
                state     <= WRITE;
              end
            end
          end
        end
        WRITE: begin
          if (accept) begin
            if (last) begin
              avm_write <= 1'b0;
              if (mode_q == MODE_WRRD) begin
                avm_read      <= 1'b1;
                avm_address   <= base_q;
                avm_writedata <= seed_q;
                left_q        <= num_q;
                state         <= READ;
              end else begin
                avm_chipselect <= 1'b0;
                busy           <= 1'b0;
                done           <= 1'b1;
                state          <= DONE;
              end
            end else begin
              avm_address   <= wrap_inc(avm_address);
              avm_writedata <= avm_writedata + 32'd1;
              left_q        <= left_q - CNT_W'(1);
            end
          end
        end
        READ: begin
          if (accept) begin
            if (last) begin
              avm_chipselect <= 1'b0;
              avm_read       <= 1'b0;
              state          <= DRAIN;
            end else begin
              avm_address   <= wrap_inc(avm_address);
              avm_writedata <= avm_writedata + 32'd1;
              left_q        <= left_q - CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          // An empty pipe means no compare lands this cycle, so err_count is final
          if (!pipe_busy) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0);
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hello_mem_test_master.sv
// Directed bench for hello_mem_test_master: latency-1 DUT (a) and latency-3 DUT (b), each with a RAM model.
module tb_hello_mem_test_master;

  localparam int DEPTH = 25600;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // DUT a: READ_LATENCY = 1
  logic        start_a, busy_a, done_a, pass_a, cs_a, wr_a, rd_a;
  logic        wait_a = 1'b0;
  logic [1:0]  mode_a;
  logic [14:0] base_a, addr_a;
  logic [15:0] num_a, err_a;
  logic [31:0] seed_a, wd_a, rdata_a;
  logic [3:0]  be_a;
  // DUT b: READ_LATENCY = 3
  logic        start_b, busy_b, done_b, pass_b, cs_b, wr_b, rd_b;
  logic        wait_b = 1'b0;
  logic [1:0]  mode_b;
  logic [14:0] base_b, addr_b;
  logic [15:0] num_b, err_b;
  logic [31:0] seed_b, wd_b, rdata_b;
  logic [3:0]  be_b;
`ifdef HELLO_MEM_TEST_ERR_CAPTURE_EN
  logic [14:0] fea_a, fea_b;
  logic [31:0] fee_a, feg_a, fee_b, feg_b;
`endif

  hello_mem_test_master #(.ADDR_W(15), .DEPTH(DEPTH), .READ_LATENCY(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .mode(mode_a), .base_addr(base_a),
    .num_words(num_a), .seed(seed_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .avm_address(addr_a), .avm_chipselect(cs_a), .avm_write(wr_a),
    .avm_read(rd_a), .avm_byteenable(be_a), .avm_writedata(wd_a), .avm_readdata(rdata_a),
    .avm_waitrequest(wait_a)
`ifdef HELLO_MEM_TEST_ERR_CAPTURE_EN
    , .first_err_addr(fea_a), .first_err_exp(fee_a), .first_err_got(feg_a)
`endif
  );

  hello_mem_test_master #(.ADDR_W(15), .DEPTH(DEPTH), .READ_LATENCY(3), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .mode(mode_b), .base_addr(base_b),
    .num_words(num_b), .seed(seed_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .avm_address(addr_b), .avm_chipselect(cs_b), .avm_write(wr_b),
    .avm_read(rd_b), .avm_byteenable(be_b), .avm_writedata(wd_b), .avm_readdata(rdata_b),
    .avm_waitrequest(wait_b)
`ifdef HELLO_MEM_TEST_ERR_CAPTURE_EN
    , .first_err_addr(fea_b), .first_err_exp(fee_b), .first_err_got(feg_b)
`endif
  );

  // RAM models; a read of address bad_x returns the stored word inverted
  bit [31:0] mem_a [DEPTH];
  bit [31:0] mem_b [DEPTH];
  bit [31:0] dly_a [4];
  bit [31:0] dly_b [4];
  int bad_a = -1, bad_b = -1;
  int wr_tot_a = 0, rd_tot_a = 0, cs_tot_a = 0, done_tot_a = 0, be_bad_a = 0;
  int rd_tot_b = 0, done_tot_b = 0;
  int wr_log_a [64];

  always @(posedge clk) begin
    if (cs_a) cs_tot_a <= cs_tot_a + 1;
    if (cs_a && be_a != 4'hF) be_bad_a <= be_bad_a + 1;
    if (cs_a && wr_a && !wait_a) begin
      mem_a[addr_a]            <= wd_a;
      wr_log_a[wr_tot_a % 64]  <= int'(addr_a);
      wr_tot_a                 <= wr_tot_a + 1;
    end
    if (cs_a && rd_a && !wait_a) rd_tot_a <= rd_tot_a + 1;
    dly_a[0] <= (cs_a && rd_a && !wait_a) ?
                (mem_a[addr_a] ^ ((int'(addr_a) == bad_a) ? 32'hFFFF_FFFF : 32'h0)) : 32'hDEAD_BEEF;
    for (int k = 1; k < 4; k++) dly_a[k] <= dly_a[k-1];
    if (done_a) done_tot_a <= done_tot_a + 1;
  end
  assign rdata_a = dly_a[0];

  always @(posedge clk) begin
    if (cs_b && wr_b && !wait_b) mem_b[addr_b] <= wd_b;
    if (cs_b && rd_b && !wait_b) rd_tot_b <= rd_tot_b + 1;
    dly_b[0] <= (cs_b && rd_b && !wait_b) ?
                (mem_b[addr_b] ^ ((int'(addr_b) == bad_b) ? 32'hFFFF_FFFF : 32'h0)) : 32'hDEAD_BEEF;
    for (int k = 1; k < 4; k++) dly_b[k] <= dly_b[k-1];
    if (done_b) done_tot_b <= done_tot_b + 1;
  end
  assign rdata_b = dly_b[2];

  // Random 0-3 cycle stalls per transfer; on a, stalled requests must hold steady
  bit stall_en_a = 1'b0, stall_en_b = 1'b0;
  bit arm_a = 1'b0, arm_b = 1'b0, hold_v = 1'b0;
  int st_n_a = 0, st_n_b = 0, stall_tot_a = 0;
  logic [49:0] hold_bus;

  always @(negedge clk) begin
    if (hold_v) chk("stall_stable", {14'h0, cs_a, wr_a, rd_a, addr_a, wd_a}, {14'h0, hold_bus});
    if (!stall_en_a) begin
      wait_a = 1'b0;
      arm_a  = 1'b0;
    end else if (cs_a && (wr_a || rd_a)) begin
      if (!arm_a) begin
        st_n_a = $urandom_range(0, 3);
        arm_a  = 1'b1;
      end
      if (st_n_a > 0) begin
        wait_a = 1'b1;
        st_n_a--;
        stall_tot_a++;
      end else begin
        wait_a = 1'b0;
        arm_a  = 1'b0;
      end
    end else begin
      wait_a = 1'b0;
    end
    hold_v   = wait_a && cs_a && (wr_a || rd_a);
    hold_bus = {1'b1, wr_a, rd_a, addr_a, wd_a};
  end

  always @(negedge clk) begin
    if (!stall_en_b) begin
      wait_b = 1'b0;
      arm_b  = 1'b0;
    end else if (cs_b && (wr_b || rd_b)) begin
      if (!arm_b) begin
        st_n_b = $urandom_range(0, 3);
        arm_b  = 1'b1;
      end
      if (st_n_b > 0) begin
        wait_b = 1'b1;
        st_n_b--;
      end else begin
        wait_b = 1'b0;
        arm_b  = 1'b0;
      end
    end else begin
      wait_b = 1'b0;
    end
  end

  task automatic go(input bit sel, input logic [1:0] m, input logic [14:0] b,
                    input logic [15:0] n, input logic [31:0] s);
    @(posedge clk); #1;
    if (sel) begin
      mode_b = m; base_b = b; num_b = n; seed_b = s; start_b = 1'b1;
    end else begin
      mode_a = m; base_a = b; num_a = n; seed_a = s; start_a = 1'b1;
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic finish_run(input bit sel, input int budget, output int cyc);
    cyc = 0;
    while (!(sel ? done_b : done_a) && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_reached", sel ? done_b : done_a, 1'b1);
    @(posedge clk); #1;
    chk("done_one_cycle", sel ? done_b : done_a, 1'b0);
  endtask

  int cyc, w0, r0, c0, d0, s0, k;

  initial begin
    reset_n = 1'b0;
    start_a = 1'b0; mode_a = 2'b00; base_a = '0; num_a = '0; seed_a = '0;
    start_b = 1'b0; mode_b = 2'b00; base_b = '0; num_b = '0; seed_b = '0;
    #12;
    chk("rst_ctrl_a", {busy_a, done_a, pass_a, cs_a, wr_a, rd_a}, 6'b001000);
    chk("rst_err_a", err_a, 16'h0);
    chk("rst_bus_a", {addr_a, wd_a, be_a}, 51'h0);
    chk("rst_ctrl_b", {busy_b, done_b, pass_b, cs_b, err_b}, {4'b0010, 16'h0});
    @(negedge clk) reset_n = 1'b1;

    // Write then verify, 8 words
    w0 = wr_tot_a; r0 = rd_tot_a; d0 = done_tot_a;
    go(0, 2'b11, 15'h0010, 16'd8, 32'hA5A5_0000);
    chk("busy_after_start", busy_a, 1'b1);
    finish_run(0, 100, cyc);
    chk("wv_cycles", cyc, 18);
    chk("wv_writes", wr_tot_a - w0, 8);
    chk("wv_reads", rd_tot_a - r0, 8);
    chk("wv_done_once", done_tot_a - d0, 1);
    chk("wv_err", err_a, 16'd0);
    chk("wv_pass", pass_a, 1'b1);
    chk("wv_be", be_bad_a, 0);
    for (int i = 0; i < 8; i++) chk("wv_mem", mem_a[16 + i], 32'hA5A5_0000 + i);

    // Verify only with word 2 corrupted
    bad_a = 16'h0012; r0 = rd_tot_a; w0 = wr_tot_a;
    go(0, 2'b10, 15'h0010, 16'd4, 32'hA5A5_0000);
    finish_run(0, 100, cyc);
    chk("cor_cycles", cyc, 6);
    chk("cor_err", err_a, 16'd1);
    chk("cor_pass", pass_a, 1'b0);
    chk("cor_reads", rd_tot_a - r0, 4);
    chk("cor_no_writes", wr_tot_a - w0, 0);
`ifdef HELLO_MEM_TEST_ERR_CAPTURE_EN
    chk("cor_fe_addr", fea_a, 15'h0012);
    chk("cor_fe_exp", fee_a, 32'hA5A5_0002);
    chk("cor_fe_got", feg_a, 32'h5A5A_FFFD);
`endif
    bad_a = -1;

    // Wrong seed: every word mismatches
    go(0, 2'b10, 15'h0010, 16'd8, 32'hA5A5_0001);
    finish_run(0, 100, cyc);
    chk("seed_err", err_a, 16'd8);
    chk("seed_pass", pass_a, 1'b0);

    // Address wrap at DEPTH-1
    w0 = wr_tot_a; r0 = rd_tot_a;
    go(0, 2'b01, 15'd25598, 16'd4, 32'h1234_5678);
    finish_run(0, 100, cyc);
    chk("wrap_cycles", cyc, 4);
    chk("wrap_writes", wr_tot_a - w0, 4);
    chk("wrap_reads", rd_tot_a - r0, 0);
    chk("wrap_a0", wr_log_a[(w0 + 0) % 64], 25598);
    chk("wrap_a1", wr_log_a[(w0 + 1) % 64], 25599);
    chk("wrap_a2", wr_log_a[(w0 + 2) % 64], 0);
    chk("wrap_a3", wr_log_a[(w0 + 3) % 64], 1);
    chk("wrap_mem0", mem_a[0], 32'h1234_567A);
    chk("wrap_mem1", mem_a[1], 32'h1234_567B);
    chk("wrap_err_cleared", err_a, 16'd0);
    chk("wrap_pass", pass_a, 1'b1);

    // num_words = 0 and mode = 00: no bus activity, done two cycles after start
    c0 = cs_tot_a;
    go(0, 2'b11, 15'h0010, 16'd0, 32'h0);
    chk("nw0_busy", busy_a, 1'b1);
    finish_run(0, 20, cyc);
    chk("nw0_cycles", cyc, 1);
    chk("nw0_pass", pass_a, 1'b1);
    go(0, 2'b00, 15'h0010, 16'd5, 32'h0);
    finish_run(0, 20, cyc);
    chk("nop_cycles", cyc, 1);
    chk("nop_no_cs", cs_tot_a - c0, 0);

    // Start pulsed mid-run is ignored
    w0 = wr_tot_a; r0 = rd_tot_a; d0 = done_tot_a;
    go(0, 2'b01, 15'h0100, 16'd6, 32'h5550_0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mode_a = 2'b11; base_a = 15'h0300; num_a = 16'd2; seed_a = 32'h0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    finish_run(0, 100, cyc);
    chk("mid_writes", wr_tot_a - w0, 6);
    chk("mid_reads", rd_tot_a - r0, 0);
    chk("mid_done_once", done_tot_a - d0, 1);
    chk("mid_last_word", mem_a[16'h0105], 32'h5550_0005);
    chk("mid_untouched", mem_a[16'h0300], 32'h0);

    // Random waitrequest stalls
    stall_en_a = 1'b1; w0 = wr_tot_a; r0 = rd_tot_a; s0 = stall_tot_a;
    go(0, 2'b11, 15'h0200, 16'd8, 32'hC0DE_0000);
    finish_run(0, 400, cyc);
    chk("st_err", err_a, 16'd0);
    chk("st_pass", pass_a, 1'b1);
    chk("st_writes", wr_tot_a - w0, 8);
    chk("st_reads", rd_tot_a - r0, 8);
    chk("st_mem0", mem_a[16'h0200], 32'hC0DE_0000);
    chk("st_mem7", mem_a[16'h0207], 32'hC0DE_0007);
    chk("st_seen", (stall_tot_a - s0) > 0, 1'b1);
    bad_a = 16'h0203;
    go(0, 2'b10, 15'h0200, 16'd8, 32'hC0DE_0000);
    finish_run(0, 400, cyc);
    chk("st_cor_err", err_a, 16'd1);
    chk("st_cor_pass", pass_a, 1'b0);
    bad_a = -1; stall_en_a = 1'b0;

    // READ_LATENCY = 3
    r0 = rd_tot_b;
    go(1, 2'b11, 15'h0020, 16'd6, 32'h0BAD_F00D);
    finish_run(1, 100, cyc);
    chk("l3_cycles", cyc, 16);
    chk("l3_err", err_b, 16'd0);
    chk("l3_pass", pass_b, 1'b1);
    chk("l3_reads", rd_tot_b - r0, 6);
    stall_en_b = 1'b1; bad_b = 16'h0022;
    go(1, 2'b10, 15'h0020, 16'd6, 32'h0BAD_F00D);
    finish_run(1, 400, cyc);
    chk("l3_st_cor_err", err_b, 16'd1);
    chk("l3_st_cor_pass", pass_b, 1'b0);
    bad_b = -1;
    go(1, 2'b10, 15'h0020, 16'd6, 32'h0BAD_F00D);
    finish_run(1, 400, cyc);
    chk("l3_st_err", err_b, 16'd0);
    chk("l3_st_pass", pass_b, 1'b1);
    chk("l3_done_count", done_tot_b, 3);
    stall_en_b = 1'b0;

    // Reset during READ abandons the run
    go(0, 2'b11, 15'h0040, 16'd8, 32'h7777_0000);
    k = 0;
    while (!rd_a && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rr_reached_read", rd_a, 1'b1);
    d0 = done_tot_a;
    #2 reset_n = 1'b0;
    #1;
    chk("rr_ctrl", {busy_a, done_a, pass_a, cs_a, wr_a, rd_a}, 6'b001000);
    chk("rr_bus", {err_a, addr_a, wd_a, be_a}, 67'h0);
    @(negedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rr_no_done", done_tot_a - d0, 0);
    go(0, 2'b11, 15'h0040, 16'd4, 32'h7777_0000);
    finish_run(0, 100, cyc);
    chk("rr_rerun_cycles", cyc, 10);
    chk("rr_rerun_err", err_a, 16'd0);
    chk("rr_rerun_pass", pass_a, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hello_mem_test_master.md
Name: hello_mem_test_master

Overview:
- Avalon-MM initiator that drives the word-addressed on-chip memory slave (32-bit data, 15-bit word address, byte enables, chipselect) in the hello system.
- Writes a deterministic pattern over a word range, reads it back with a pipelined, fixed-latency compare, and reports an error count plus pass/fail.
- Used for bring-up and self-test of the on-chip RAM; sits beside the Nios II data master on the same interconnect.

Parameters:
- ADDR_W, 15, word address width of the memory slave
- DEPTH, 25600, number of words in the target memory; addresses wrap modulo DEPTH
- READ_LATENCY, 1, fixed cycles from accepted read to valid avm_readdata (1..4)
- CNT_W, 16, width of num_words and err_count

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe; ignored while busy
- mode  in  2  01 = write only, 10 = verify only, 11 = write then verify, 00 = no-op
- base_addr  in  ADDR_W  first word address
- num_words  in  CNT_W  number of words to process
- seed  in  32  pattern seed
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- pass  out  1  err_count == 0 for the last run; held until the next start
- err_count  out  CNT_W  number of mismatched words; saturates at all-ones
- avm_address  out  ADDR_W  word address
- avm_chipselect  out  1  bus request
- avm_write  out  1  write strobe
- avm_read  out  1  read strobe
- avm_byteenable  out  4  always 4'hF while chipselect is high, else 0
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data, valid READ_LATENCY cycles after read acceptance
- avm_waitrequest  in  1  stall; tie to 0 for the on-chip RAM

Behaviour:
- Reset, asynchronous: FSM goes to IDLE; every output is 0 except pass, which resets to 1; read pipe is cleared.
- Pattern: word i carries seed + i (mod 2^32). Its address is (base_addr + i) mod DEPTH, produced by an incrementing pointer that wraps DEPTH-1 -> 0.
- Transfer acceptance: a transfer is accepted in any cycle where chipselect & (read | write) & ~waitrequest.
- Stalls: address, data and strobes are held stable while waitrequest is high.
- FSM states:
  - IDLE: on start with mode != 00, latch the operands, clear err_count, and go to WRITE (mode bit0) or READ.
  - WRITE: issue one write per accepted cycle. After the last write is accepted, go to READ if mode bit1 is set, else DONE.
  - READ: issue one read per accepted cycle and push the expected word into a READ_LATENCY-deep valid/expected shift register. After the last read is accepted, go to DRAIN.
  - DRAIN: wait until the pipe is empty, then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Compare: each pipe entry that reaches the end of the shift register is compared with avm_readdata. A mismatch increments err_count, saturating.
- Throughput: back-to-back issue, one word per cycle when waitrequest = 0.
- num_words == 0 or mode == 00: no bus activity; done pulses 2 cycles after start; pass = 1.
- start while busy: ignored; operands do not change.
- Simultaneous start and done cycle: start is ignored.
- Reset mid-run: strobes deassert immediately; the run is abandoned with no done pulse.

Optional Feature:
- Macro: HELLO_MEM_TEST_ERR_CAPTURE_EN.
- Defined:
  - Adds outputs first_err_addr[ADDR_W], first_err_exp[32] and first_err_got[32], captured on the first mismatch of a run.
  - Cleared to 0 on start and on reset.
- Undefined: these ports and their registers are absent.

Decomposition:
- Package hello_mem_test_pkg holds:
  - the state enum (IDLE, WRITE, READ, DRAIN, DONE);
  - the mode encodings;
  - the BE_ALL = 4'hF constant.
- One sub-module, hello_mem_test_rdpipe: the READ_LATENCY-deep valid/expected shift register with a compare output. The FSM, counters and address wrap stay in the top module.

Test Plan:
- Write then verify, mode=11, base=0x0010, num_words=8, seed=0xA5A50000, RAM model with latency 1:
  - 8 writes of 0xA5A50000..0xA5A50007, then 8 reads;
  - done once; err_count=0; pass=1.
- Corruption: verify only, mode=10, over 4 words after the bench corrupts word 2 (addr base+2):
  - err_count=1; pass=0;
  - with HELLO_MEM_TEST_ERR_CAPTURE_EN, first_err_addr=base+2.
- Wrap: base=25598, num_words=4, mode=01 -> writes hit addresses 25598, 25599, 0, 1.
- waitrequest: random 0-3 cycle stalls on every transfer:
  - strobes, address and data stay stable while stalled;
  - result identical to the no-stall run; READ_LATENCY=3 variant also passes.
- Edge commands:
  - num_words=0 -> no chipselect; done 2 cycles after start; pass=1;
  - start pulsed mid-run -> ignored.
- Reset mid-run: assert reset_n=0 during READ -> all outputs 0 and pass=1 asynchronously; a new run afterwards completes normally.
